// File: rtl/mode_sel_pkg.sv
// Shared types and helpers for the mode-select menu FSM.
package mode_sel_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BROWSE = 2'b01,
      COMMIT = 2'b10
   } state_t;

   function automatic int unsigned wrap_inc(input int unsigned x,
                                            input int unsigned n);
      return (x == n - 1) ? 32'd0 : x + 32'd1;
   endfunction

endpackage

// File: rtl/mode_sel_fsm_btn_edge.sv
// Button rise detector; MODE_SEL_SYNC_EN adds a 2-flop synchroniser in front.
module btn_edge
   import mode_sel_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic rise
);

   logic src;
   logic prev_q;

`ifdef MODE_SEL_SYNC_EN
   logic s1_q, s2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= in;
         s2_q <= s1_q;
      end
   end

   assign src = s2_q;
`else
   assign src = in;
`endif

   // prev_q resets low so a button held through reset counts as one edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b0;
      else        prev_q <= src;
   end

   assign rise = src & ~prev_q;

endmodule

// File: rtl/mode_sel_fsm.sv
// Clocked op/select menu FSM choosing the datapath mode.
// Define MODE_SEL_SYNC_EN to synchronise asynchronous button inputs.
module mode_sel_fsm
   import mode_sel_pkg::*;
#(
   parameter int NUM_MODES      = 4,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int MODE_W        = $clog2(NUM_MODES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op,
   input  logic              select,
   output state_t            state,
   output logic [MODE_W-1:0] cand_mode,
   output logic [MODE_W-1:0] active_mode,
   output logic              commit_pulse,
   output logic              busy
);

   localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT_CYCLES - 1);

   state_t              state_q, state_d;
   logic [MODE_W-1:0]   cand_q, cand_d;
   logic [MODE_W-1:0]   active_q, active_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                op_rise, sel_rise;

   function automatic logic [MODE_W-1:0] inc(input logic [MODE_W-1:0] x);
      return MODE_W'(wrap_inc(32'(x), NUM_MODES));
   endfunction

   btn_edge u_op_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (op),
      .rise  (op_rise)
   );

   btn_edge u_sel_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (select),
      .rise  (sel_rise)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         active_q <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         active_q <= active_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      active_d = active_q;
      timer_d  = '0;
      case (state_q)
         IDLE: begin
            cand_d = active_q;
            if (op_rise) begin
               state_d = BROWSE;
               cand_d  = inc(active_q);
            end
         end
         BROWSE: begin
            if (sel_rise) begin
               state_d  = COMMIT;
               active_d = cand_q;
            end else if (op_rise) begin
               cand_d = inc(cand_q);
            end else if (timer_q == TMAX) begin
               state_d = IDLE;
               cand_d  = active_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            cand_d  = active_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // all outputs decode registered state only
   assign state        = state_q;
   assign cand_mode    = cand_q;
   assign active_mode  = active_q;
   assign commit_pulse = (state_q == COMMIT);
   assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mode_sel_fsm.sv
// Scoreboard bench for mode_sel_fsm (NUM_MODES=4, TIMEOUT_CYCLES=16).
module tb_mode_sel_fsm;
   import mode_sel_pkg::*;

`ifdef MODE_SEL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       op = 1'b0;
   logic       select = 1'b0;
   state_t     state;
   logic [1:0] cand_mode;
   logic [1:0] active_mode;
   logic       commit_pulse;
   logic       busy;

   mode_sel_fsm #(
      .NUM_MODES      (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op           (op),
      .select       (select),
      .state        (state),
      .cand_mode    (cand_mode),
      .active_mode  (active_mode),
      .commit_pulse (commit_pulse),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         stamp;
      state_t     st;
      logic [1:0] cand;
      logic [1:0] act;
   } exp_t;

   exp_t       q[$];
   logic [1:0] cq[$];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   task automatic chk_now(input string name, input state_t es,
                          input logic [1:0] ec, input logic [1:0] ea);
      logic ecp, eb;
      ecp = (es == COMMIT);
      eb  = (es != IDLE);
      checks++;
      if (state !== es || cand_mode !== ec || active_mode !== ea ||
          commit_pulse !== ecp || busy !== eb) begin
         failures++;
         $display("FAIL %s: got st=%0d cand=%0d act=%0d cp=%0b busy=%0b want st=%0d cand=%0d act=%0d cp=%0b busy=%0b",
                  name, state, cand_mode, active_mode, commit_pulse, busy,
                  es, ec, ea, ecp, eb);
      end
   endtask

   // Monitor: pops expectations due this cycle, and matches commit pulses
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].stamp <= cyc) begin
            e = q.pop_front();
            if (e.stamp < cyc) begin
               checks++;
               failures++;
               $display("FAIL stale_expect: stamp=%0d cycle=%0d",
                        e.stamp, cyc);
            end else begin
               chk_now($sformatf("cycle_%0d", cyc), e.st, e.cand, e.act);
            end
         end
         if (rst_n && commit_pulse) begin
            checks++;
            if (cq.size() == 0) begin
               failures++;
               $display("FAIL commit_unexpected: got act=%0d want no pulse",
                        active_mode);
            end else begin
               logic [1:0] ea;
               ea = cq.pop_front();
               if (active_mode !== ea) begin
                  failures++;
                  $display("FAIL commit_mode: got %0d want %0d",
                           active_mode, ea);
               end
            end
         end
      end
   end

   // Drive one cycle of inputs and queue the state expected after that edge
   task automatic step(input logic o, input logic s, input state_t es,
                       input logic [1:0] ec, input logic [1:0] ea);
      exp_t e;
      @(posedge clk);
      #2;
      op     = o;
      select = s;
      e.stamp = cyc + 1 + LAT;
      e.st    = es;
      e.cand  = ec;
      e.act   = ea;
      q.push_back(e);
      if (es == COMMIT) cq.push_back(ea);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: got pending=%0d want 0", name, q.size());
         q.delete();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #2;
      chk_now("reset_state", IDLE, 2'd0, 2'd0);
      rst_n = 1'b1;

      // three op steps then commit
      step(1, 0, BROWSE, 2'd1, 2'd0);
      step(0, 0, BROWSE, 2'd1, 2'd0);
      step(1, 0, BROWSE, 2'd2, 2'd0);
      step(0, 0, BROWSE, 2'd2, 2'd0);
      step(1, 0, BROWSE, 2'd3, 2'd0);
      step(0, 0, BROWSE, 2'd3, 2'd0);
      step(0, 1, COMMIT, 2'd3, 2'd3);
      step(0, 0, IDLE,   2'd3, 2'd3);

      // wrap 3 -> 0
      step(1, 0, BROWSE, 2'd0, 2'd3);
      step(0, 0, BROWSE, 2'd0, 2'd3);
      step(0, 1, COMMIT, 2'd0, 2'd0);
      step(0, 0, IDLE,   2'd0, 2'd0);

      // timeout after 16 browse cycles
      step(1, 0, BROWSE, 2'd1, 2'd0);
      for (int i = 0; i < 15; i++) step(0, 0, BROWSE, 2'd1, 2'd0);
      step(0, 0, IDLE, 2'd0, 2'd0);
      step(0, 0, IDLE, 2'd0, 2'd0);

      // simultaneous edges: op wins in IDLE, select wins in BROWSE
      step(1, 1, BROWSE, 2'd1, 2'd0);
      step(0, 0, BROWSE, 2'd1, 2'd0);
      step(1, 1, COMMIT, 2'd1, 2'd1);
      step(0, 0, IDLE,   2'd1, 2'd1);

      // held op gives one increment
      for (int i = 0; i < 10; i++) step(1, 0, BROWSE, 2'd2, 2'd1);
      step(0, 0, BROWSE, 2'd2, 2'd1);
      step(0, 1, COMMIT, 2'd2, 2'd2);
      // op edge during COMMIT is consumed
      step(1, 0, IDLE, 2'd2, 2'd2);
      step(1, 0, IDLE, 2'd2, 2'd2);
      step(0, 0, IDLE, 2'd2, 2'd2);
      // select alone in IDLE is ignored
      step(0, 1, IDLE, 2'd2, 2'd2);
      step(0, 1, IDLE, 2'd2, 2'd2);
      step(0, 0, IDLE, 2'd2, 2'd2);

      // async reset mid-BROWSE
      step(1, 0, BROWSE, 2'd3, 2'd2);
      step(0, 0, BROWSE, 2'd3, 2'd2);
      drain("pre_reset");
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_now("async_reset", IDLE, 2'd0, 2'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      step(0, 0, IDLE,   2'd0, 2'd0);
      step(1, 0, BROWSE, 2'd1, 2'd0);
      step(0, 1, COMMIT, 2'd1, 2'd1);
      step(0, 0, IDLE,   2'd1, 2'd1);
      drain("final");

      checks++;
      if (cq.size() != 0) begin
         failures++;
         $display("FAIL commit_missing: got pending=%0d want 0", cq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mode_sel_fsm.md
Name: mode_sel_fsm

Overview:
- Registered successor to the combinational op/select next-state logic: a clocked menu FSM selecting one of NUM_MODES operating modes.
- Rising edges on `op` step a candidate mode (with wrap-around). A rising edge on `select` commits the candidate. An inactivity timer abandons browsing.
- Sits between the user button inputs and the datapath mode mux. The datapath sees only `active_mode` and `commit_pulse`.

Parameters:
- NUM_MODES, 4, number of selectable modes; legal range >= 2.
- TIMEOUT_CYCLES, 16, cycles without an op/select edge before BROWSE aborts; legal range >= 2.
- MODE_W, $clog2(NUM_MODES), derived localparam; width of mode outputs.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  1  step button, level; synchronous to clk unless MODE_SEL_SYNC_EN is defined.
- select  in  1  commit button, level; same timing rule as op.
- state  out  2  current FSM state (mode_sel_pkg::state_t).
- cand_mode  out  MODE_W  mode currently being browsed.
- active_mode  out  MODE_W  last committed mode; drives the datapath.
- commit_pulse  out  1  one-cycle high in the cycle after a commit.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cand_mode=0, active_mode=0, commit_pulse=0, busy=0, timer=0, edge registers op_q=sel_q=0.
  - An input already high at reset release counts as a rising edge on the first clock.
  - Reset mid-BROWSE discards the candidate. active_mode returns to 0.
- Edge detection:
  - op_rise = op & ~op_q; sel_rise = select & ~sel_q.
  - op_q and sel_q are updated every cycle.
  - Holding a button high produces exactly one event.
- Latency: an edge sampled at clock k updates the registered outputs after edge k. Outputs are registered only; no combinational path from input to output.
- Wrap increment: inc(x) = (x == NUM_MODES-1) ? 0 : x+1. Never produces values >= NUM_MODES.
- State IDLE (00):
  - cand_mode tracks active_mode.
  - op_rise -> BROWSE, cand_mode = inc(active_mode), timer = 0.
  - sel_rise alone is ignored.
  - op_rise and sel_rise together -> op wins (enter BROWSE).
- State BROWSE (01):
  - sel_rise -> COMMIT, active_mode = cand_mode. Takes priority over a simultaneous op_rise.
  - Otherwise op_rise -> cand_mode = inc(cand_mode), timer = 0.
  - Otherwise, if timer == TIMEOUT_CYCLES-1 -> IDLE, cand_mode = active_mode, timer = 0.
  - Otherwise timer++.
  - Net effect: BROWSE lasts exactly TIMEOUT_CYCLES cycles after the last op edge.
- State COMMIT (10):
  - Held for one cycle; commit_pulse = 1 during this cycle only; next state is always IDLE.
  - Edges arriving in COMMIT are consumed, i.e. ignored. op_q and sel_q still update.
- State 11: unreachable. If entered, next state is IDLE with no output side effects.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer is held at 0 outside BROWSE.

Optional Feature:
- Macro: MODE_SEL_SYNC_EN.
- When defined:
  - op and select each pass through a 2-flop synchroniser, reset to 0, before edge detection.
  - Input-to-output latency becomes 3 cycles. Inputs may then be asynchronous.
- When undefined: inputs are used directly, with 1-cycle latency as above.
- Ports and all other behaviour are identical in both builds.

Decomposition:
- Package mode_sel_pkg:
  - typedef enum logic [1:0] state_t {IDLE=2'b00, BROWSE=2'b01, COMMIT=2'b10}.
  - Function wrap_inc(x, n).
- Sub-module btn_edge:
  - Ports clk, rst_n, in, rise.
  - Contains the optional MODE_SEL_SYNC_EN synchroniser plus the rise detector.
  - Instantiated twice, once for op and once for select.
- All FSM, timer and mode registers live in mode_sel_fsm.

Test Plan (NUM_MODES=4, TIMEOUT_CYCLES=16, macro undefined unless noted):
- Reset, then 3 single-cycle op pulses spaced 2 cycles apart, then a select pulse -> cand_mode goes 1,2,3; after the select edge state=COMMIT, active_mode=3, commit_pulse high for exactly 1 cycle; state=IDLE on the following cycle.
- From active_mode=3, one op pulse -> cand_mode=0 (wrap). Then select -> active_mode=0.
- One op pulse, then idle -> busy high for 16 cycles, then state=IDLE, cand_mode=active_mode, commit_pulse never asserted.
- op and select rising in the same cycle in IDLE -> BROWSE with cand=inc(active). Same stimulus again in BROWSE -> COMMIT, cand unchanged.
- op held high for 10 cycles -> exactly one increment. select asserted in IDLE -> no state change.
- rst_n pulsed low mid-BROWSE, asynchronously between clock edges -> all outputs 0 and state=IDLE immediately. Rerun scenario 1 with MODE_SEL_SYNC_EN defined -> each response 2 cycles later.
